// File: rtl/add44_pkg.sv
// Shared widths and operand/sum types for the 4-bit adder leaf.
package add44_pkg;

    localparam int OPW  = 4;
    localparam int SUMW = OPW + 1;

    typedef logic [OPW-1:0]  opnd_t;
    typedef logic [SUMW-1:0] sum_t;

endpackage

// File: rtl/add44_full_adder.sv
// Single-bit full adder: one stage of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared by the sum and the carry-out.
    always_comb begin
        p  = a ^ b;
        s  = p ^ ci;
        co = (a & b) | (ci & p);
    end

endmodule

// File: rtl/add44.sv
// Unsigned 4-bit + 4-bit ripple-carry adder with a full 5-bit sum,
// exposed both combinationally (SUM) and registered (SUM_Q).
module add44
    import add44_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic [OPW-1:0]  A,
    input  logic [OPW-1:0]  B,
    output logic [SUMW-1:0] SUM,
    output logic [SUMW-1:0] SUM_Q
);

    logic [OPW:0]   c;
    logic [OPW-1:0] s;

    // Carry into bit 0 is fixed at zero.
    always_comb begin
        c[0] = 1'b0;
    end

    for (genvar i = 0; i < OPW; i++) begin : g_stage
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Final carry becomes the sum MSB.
    always_comb begin
        SUM = {c[OPW], s};
    end

    // Registered copy of the sum; reset wins over capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SUM_Q <= '0;
        end else begin
            SUM_Q <= SUM;
        end
    end

endmodule

// File: tb/tb_add44.sv
// Self-checking bench for add44: directed combinational cases, an
// exhaustive sweep, random vectors, reset behaviour and streaming.
module tb_add44;

    logic       CLK;
    logic       RST;
    logic [3:0] A;
    logic [3:0] B;
    logic [4:0] SUM;
    logic [4:0] SUM_Q;

    bit run_clk;
    int vectors;
    int miscompares;

    add44 dut (
        .CLK   (CLK),
        .RST   (RST),
        .A     (A),
        .B     (B),
        .SUM   (SUM),
        .SUM_Q (SUM_Q)
    );

    // Clock toggles only once the bench enables it.
    always begin
        #5;
        if (run_clk) CLK = ~CLK;
    end

    function automatic logic [4:0] ref_sum(input logic [3:0] x, input logic [3:0] y);
        int unsigned t;
        t = int'(x) + int'(y);
        return t[4:0];
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic comb_case(input string tag, input logic [3:0] x, input logic [3:0] y,
                             input logic [4:0] exp);
        A = x;
        B = y;
        #1;
        check(tag, SUM, exp);
    endtask

    initial begin
        logic [4:0] exp_q;
        logic [3:0] ra;
        logic [3:0] rb;

        vectors     = 0;
        miscompares = 0;
        run_clk     = 1'b0;
        CLK         = 1'b0;
        RST         = 1'b0;
        A           = '0;
        B           = '0;

        // Directed combinational cases with the clock idle.
        comb_case("zero",       4'b0000, 4'b0000, 5'b00000);
        comb_case("one_one",    4'b0001, 4'b0001, 5'b00010);
        comb_case("ripple2",    4'b0011, 4'b0001, 5'b00100);
        comb_case("7_plus_3",   4'b0111, 4'b0011, 5'b01010);
        comb_case("carry_out",  4'b1111, 4'b0111, 5'b10110);
        comb_case("max",        4'b1111, 4'b1111, 5'b11110);
        comb_case("full_prop",  4'b1111, 4'b0001, 5'b10000);

        // Combinational result must not depend on RST.
        RST = 1'b1;
        comb_case("rst_high",   4'b1010, 4'b0110, 5'b10000);
        RST = 1'b0;

        // Exhaustive sweep against plain arithmetic.
        for (int unsigned i = 0; i < 16; i++) begin
            for (int unsigned j = 0; j < 16; j++) begin
                A = i[3:0];
                B = j[3:0];
                #1;
                check("sweep", SUM, 5'(i + j));
            end
        end

        // Random combinational vectors.
        for (int unsigned k = 0; k < 32; k++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            comb_case("rand_comb", ra, rb, ref_sum(ra, rb));
        end

        // Start the clock; hold reset for two edges with max operands.
        run_clk = 1'b1;
        A   = 4'b1111;
        B   = 4'b1111;
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst_q",   SUM_Q, 5'b00000);
        check("rst_sum", SUM,   5'b11110);

        // Release reset: capture on the next edge.
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("release_q", SUM_Q, 5'b11110);

        // Streaming with a single-cycle reset pulse in the middle.
        for (int unsigned k = 0; k < 40; k++) begin
            @(negedge CLK);
            A   = 4'($urandom);
            B   = 4'($urandom);
            RST = (k == 20);
            exp_q = RST ? 5'b00000 : ref_sum(A, B);
            #1;
            check("stream_sum", SUM, ref_sum(A, B));
            @(posedge CLK);
            #1;
            check(RST ? "stream_rst" : "stream_q", SUM_Q, exp_q);
        end

        @(negedge CLK);
        RST = 1'b0;
        run_clk = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/add44.md
# add44

Unsigned 4-bit + 4-bit adder producing a full 5-bit sum with no overflow loss. It is the basic arithmetic leaf of the design, built structurally as a 4-stage ripple-carry chain of full adders. The combinational sum drives downstream logic directly. A registered copy serves clocked consumers.

## Interface
- Parameters: none. Operand width is fixed at 4 bits and sum width at 5 bits.
- CLK  input  1  rising-edge clock; drives only the registered output.
- RST  input  1  synchronous, active-high reset; affects only the registered output.
- A    input  4  unsigned operand A.
- B    input  4  unsigned operand B.
- SUM  output 5  combinational sum A+B; SUM[4] is the carry-out.
- SUM_Q output 5  SUM registered on the rising edge of CLK.

## Operation
- SUM = {1'b0,A} + {1'b0,B}, exact and unsigned. The range is 0..30, so the result can never overflow 5 bits.
- Structural ripple chain, with carry-in to bit 0 tied to 0:
  - stage i: s_i = A[i]^B[i]^c_i; c_{i+1} = A[i]&B[i] | c_i&(A[i]^B[i]).
  - SUM[i] = s_i for i = 0..3; SUM[4] = c_4.
- SUM depends only on A and B. It must be correct with CLK idle and RST in any state, so the block is usable as a pure combinational adder.
- No X-propagation masking: any X/Z on an input bit may propagate to the affected sum bits.
- SUM_Q register:
  - On a rising CLK edge with RST=1: SUM_Q <= 5'b00000.
  - On a rising CLK edge with RST=0: SUM_Q <= SUM.
  - RST has priority over data capture. There is no enable; the register captures every cycle.

## Timing
- SUM has zero-cycle latency, purely combinational. The worst-case path runs from A[0]/B[0] through 4 carry stages to SUM[4].
- SUM_Q has 1-cycle latency: it reflects A and B as sampled at the previous rising edge.
- SUM_Q reset value is 00000. SUM has no reset value because it always equals A+B.
- Reset mid-operation: SUM_Q clears at the first edge where RST=1. Capture resumes at the first edge with RST=0, loading the current sum.
- Before the first clock edge, SUM_Q is unknown. Verification must not check it before the first reset.

## Structure
- Sub-module full_adder (ports a, b, ci, s, co) is instantiated 4 times in a generate loop.
- An internal carry vector c[4:0] has c[0]=0; SUM[4]=c[4].
- Shared package add44_pkg holds:
  - localparam OPW=4
  - localparam SUMW=OPW+1
  - typedef logic [OPW-1:0] opnd_t
  - typedef logic [SUMW-1:0] sum_t
- One always_ff block for SUM_Q; no other state.

## Test plan
- A=0000, B=0000 -> SUM=00000. Then A=0001, B=0001 -> SUM=00010, with no clock running.
- A=0011, B=0001 -> SUM=00100, exercising a 2-stage carry ripple. A=0111, B=0011 -> SUM=01010.
- A=1111, B=0111 -> SUM=10110, with carry-out set. A=1111, B=1111 -> SUM=11110 (maximum).
- Exhaustively sweep all 256 A/B pairs and compare SUM to a behavioural A+B. Also exercise A=1111, B=0001 -> SUM=10000, the full carry propagation.
- Hold RST=1 for 2 clocks with A=1111, B=1111 -> SUM_Q=00000 while SUM=11110. Release RST -> SUM_Q=11110 one edge later.
- Streaming: change A/B every cycle -> SUM_Q equals the previous cycle's SUM. Assert RST for one cycle mid-stream -> SUM_Q=00000 for exactly that cycle, then tracking resumes.
